// File: rtl/fadd_issue.sv
// Issue/return wrapper for a fixed-latency fadd datapath: credit-limited accept,
// tag shift register and FWFT result FIFO. Define FADD_ISSUE_SUB_EN to enable subtraction.
module fadd_issue #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fa_x1,
    output logic [31:0]      fa_x2,
    input  logic [31:0]      fa_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [LATENCY-1:0] sr_valid;
    logic [TAG_W-1:0]   sr_tag [LATENCY];
    logic [31:0]        mem_y [DEPTH];
    logic [TAG_W-1:0]   mem_tag [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credits_used;
    logic               accept;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits come from registered counts only, so a pop frees its slot next cycle.
    assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready     = credits_used < DEPTH_SUM;
    assign accept       = in_valid && in_ready;
    assign push         = sr_valid[LATENCY-1];
    assign pop          = out_valid && out_ready;

    assign fa_x1 = in_x1;
`ifdef FADD_ISSUE_SUB_EN
    assign fa_x2 = {in_x2[31] ^ in_op, in_x2[30:0]};
`else
    assign fa_x2 = in_x2;
`endif

    assign out_valid = (fifo_count != '0);
    assign busy      = (fifo_count != '0) || (inflight != '0);
    assign out_y     = mem_y[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_valid   <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            sr_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                sr_valid[i] <= sr_valid[i-1];
            end

            if (accept && !push) begin
                inflight <= inflight + CNT_W'(1);
            end else if (push && !accept) begin
                inflight <= inflight - CNT_W'(1);
            end

            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // NOTE: tag pipeline and FIFO storage carry no reset; only valid bits and counts qualify them.
    always_ff @(posedge clk) begin
        sr_tag[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            sr_tag[i] <= sr_tag[i-1];
        end
        if (push) begin
            mem_y[wr_ptr]   <= fa_y;
            mem_tag[wr_ptr] <= sr_tag[LATENCY-1];
        end
    end

    // Credit accounting guarantees a full FIFO never receives an unmatched push.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (fifo_count == DEPTH_CNT) && !pop));
        end
    end

endmodule

// File: tb/tb_fadd_issue.sv
// Directed bench for fadd_issue with a behavioural fixed-latency fadd model and a scoreboard.
module tb_fadd_issue;

    localparam int LAT   = 4;
    localparam int DEP   = 8;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fa_x1;
    logic [31:0]      fa_x2;
    logic [31:0]      fa_y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    res_t  exp_q[$];
    int    acc_cyc_q[$];
    int    pop_cyc_q[$];
    logic [31:0]      last_y;
    logic [TAG_W-1:0] last_tag;
    logic [31:0]      fa_pipe [LAT];

    fadd_issue #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_tag(out_tag), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Exact IEEE results for the directed float vectors; integer sum stands in elsewhere.
    function automatic logic [31:0] ref_fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40800000;
        if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        return a + b;
    endfunction

    function automatic logic [31:0] eff_x2(input logic [31:0] x2, input logic op);
`ifdef FADD_ISSUE_SUB_EN
        return {x2[31] ^ op, x2[30:0]};
`else
        return x2;
`endif
    endfunction

    always @(posedge clk) begin
        fa_pipe[0] <= ref_fadd(fa_x1, fa_x2);
        for (int i = 1; i < LAT; i++) fa_pipe[i] <= fa_pipe[i-1];
    end
    assign fa_y = fa_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: predict on accept, compare on pop, both sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back('{y: ref_fadd(in_x1, eff_x2(in_x2, in_op)), tag: in_tag});
                acc_cyc_q.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                pop_cyc_q.push_back(cyc);
                last_y   = out_y;
                last_tag = out_tag;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(out_tag), 32'hFFFFFFFF);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_y", out_y, e.y);
                    check("sb_tag", 32'(out_tag), 32'(e.tag));
                end
            end
        end
    end

    task automatic clear_log();
        acc_cyc_q.delete();
        pop_cyc_q.delete();
    endtask

    task automatic offer(input int n, input int base, input int budget, output int used);
        int i;
        i = 0;
        used = 0;
        while (i < n && used < budget) begin
            in_valid = 1'b1;
            in_op    = 1'b0;
            in_x1    = 32'h2000 + 32'(base + i);
            in_x2    = 32'h5;
            in_tag   = TAG_W'(base + i);
            @(negedge clk);
            if (in_ready) i++;
            @(posedge clk);
            #1;
            used++;
        end
        in_valid = 1'b0;
        check("offer_accepts", 32'(i), 32'(n));
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k;
        k = 0;
        while (pop_cyc_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("pop_count", 32'(pop_cyc_q.size()), 32'(n));
    endtask

    task automatic single(input logic [31:0] x1, input logic [31:0] x2, input logic op,
                          input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_x1    = x1;
        in_x2    = x2;
        in_op    = op;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int used;
        rst = 1'b1; in_valid = 1'b0; in_op = 1'b0;
        in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1.0 + 2.0 with tag 3: result visible LATENCY+1 cycles after accept.
        out_ready = 1'b1;
        clear_log();
        single(32'h3F800000, 32'h40000000, 1'b0, 5'd3);
        wait_pops(1, 20);
        if (pop_cyc_q.size() == 1 && acc_cyc_q.size() == 1)
            check("lat_cycles", 32'(pop_cyc_q[0] - acc_cyc_q[0]), 32'(LAT + 1));
        check("a_y", last_y, 32'h40400000);
        check("a_tag", 32'(last_tag), 32'd3);

        // Stalled consumer: only DEPTH of 10 back-to-back offers get in.
        out_ready = 1'b0;
        clear_log();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_op    = 1'b0;
            in_x1    = 32'h1000 + 32'(i);
            in_x2    = 32'h10;
            in_tag   = TAG_W'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("full_accepts", 32'(acc_cyc_q.size()), 32'(DEP));
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("head_y", out_y, 32'h00001010);
        check("head_tag", 32'(out_tag), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_y", out_y, 32'h00001010);
        check("hold_tag", 32'(out_tag), 32'd0);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        wait_pops(DEP, 40);
        if (pop_cyc_q.size() == DEP) check("drain_last_tag", 32'(last_tag), 32'd7);
        check("drain_in_ready", 32'(in_ready), 32'd1);
        check("drain_busy", 32'(busy), 32'd0);

        // Full FIFO draining while new operations are offered concurrently.
        out_ready = 1'b0;
        clear_log();
        offer(DEP, 0, 20, used);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("refill_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        offer(6, 16, 40, used);
        wait_pops(DEP + 6, 60);
        check("mix_last_tag", 32'(last_tag), 32'd21);
        check("mix_busy", 32'(busy), 32'd0);

        // Streaming: one accept and one return per cycle.
        clear_log();
        offer(20, 0, 20, used);
        check("stream_cycles", 32'(used), 32'd20);
        wait_pops(20, 40);
        if (acc_cyc_q.size() == 20)
            check("acc_span", 32'(acc_cyc_q[19] - acc_cyc_q[0]), 32'd19);
        if (pop_cyc_q.size() == 20)
            check("pop_span", 32'(pop_cyc_q[19] - pop_cyc_q[0]), 32'd19);

        // 3.0 op=1 1.0: subtract only when the feature is built in.
        clear_log();
        single(32'h40400000, 32'h3F800000, 1'b1, 5'd9);
        wait_pops(1, 20);
`ifdef FADD_ISSUE_SUB_EN
        check("sub_y", last_y, 32'h40000000);
`else
        check("sub_y", last_y, 32'h40800000);
`endif
        check("sub_fa_x1", fa_x1, in_x1);

        // Reset with 2 buffered and 3 in flight discards everything.
        out_ready = 1'b0;
        clear_log();
        offer(2, 1, 10, used);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        offer(3, 4, 10, used);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        clear_log();
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_pops", 32'(pop_cyc_q.size()), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        single(32'h3F800000, 32'h40000000, 1'b0, 5'd17);
        wait_pops(1, 20);
        check("post_rst_tag", 32'(last_tag), 32'd17);
        check("post_rst_y", last_y, 32'h40400000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
